// File: rtl/exc_ctrl.sv
// exc_ctrl: exception and interrupt controller at the memory-stage commit point.
// Synchronises the external interrupt lines, merges them with the timer
// interrupt, arbitrates interrupt/exception/ERET events by MIPS priority, and
// issues a one-cycle flush with redirect PC plus the CP0 entry-update pulses.
// Optional feature macro: EXC_IV_EN (Cause.IV selects the 0x200 interrupt vector).
module exc_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BEV1_BASE   = 32'hBFC0_0200,
  parameter logic [31:0] BEV0_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        timer_int,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_inslot,
  input  logic [7:0]  m_exc,
  input  logic [31:0] m_addr,
  output logic        m_cancel,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [5:0]  hw_ip,
  output logic        exc_we,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        badv_we,
  output logic [31:0] badv_data,
  output logic        eret_clr
);

  typedef enum logic [1:0] {IDLE, TAKE, BLANK} state_t;

  // m_exc bit positions
  localparam int X_ADEL_IF = 0;
  localparam int X_RI      = 1;
  localparam int X_OV      = 2;
  localparam int X_SYS     = 3;
  localparam int X_BP      = 4;
  localparam int X_ADEL    = 5;
  localparam int X_ADES    = 6;
  localparam int X_ERET    = 7;

  state_t      state_q, state_d;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic        int_pend;
  logic        detect;
  logic [4:0]  ev_code;
  logic        ev_int;
  logic        ev_eret;
  logic        ev_badv;
  logic [31:0] ev_badv_data;
  logic [31:0] vec_base;
  logic [31:0] vec_off;
  logic [31:0] entry_pc;

  // Interrupt line synchroniser chain; every stage is reset so hw_ip is clean out of reset.
  // NOTE: synchroniser stages are reset like any other flop; they are state, not a RAM,
  // so clearing them costs nothing and keeps spurious interrupts out after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Registered pending bits for Cause.IP[7:2]; timer shares IP7 with ext_int[5].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hw_ip <= '0;
    else      hw_ip <= {sync_q[SYNC_STAGES-1][5] | timer_int, sync_q[SYNC_STAGES-1][4:0]};
  end

  // Interrupt is pending when globally enabled, not already in an exception, and unmasked.
  assign int_pend = status_i[0] & ~status_i[1] & (|({hw_ip, cause_i[9:8]} & status_i[15:8]));

  // Priority arbitration of the event presented at commit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    ev_code      = 5'd0;
    ev_int       = 1'b0;
    ev_eret      = 1'b0;
    ev_badv      = 1'b0;
    ev_badv_data = m_pc;
    if (int_pend) begin
      ev_int  = 1'b1;
      ev_code = 5'd0;
    end else if (m_exc[X_ADEL_IF]) begin
      ev_code      = 5'd4;
      ev_badv      = 1'b1;
      ev_badv_data = m_pc;
    end else if (m_exc[X_RI]) begin
      ev_code = 5'd10;
    end else if (m_exc[X_OV]) begin
      ev_code = 5'd12;
    end else if (m_exc[X_SYS]) begin
      ev_code = 5'd8;
    end else if (m_exc[X_BP]) begin
      ev_code = 5'd9;
    end else if (m_exc[X_ADEL]) begin
      ev_code      = 5'd4;
      ev_badv      = 1'b1;
      ev_badv_data = m_addr;
    end else if (m_exc[X_ADES]) begin
      ev_code      = 5'd5;
      ev_badv      = 1'b1;
      ev_badv_data = m_addr;
    end else if (m_exc[X_ERET]) begin
      ev_eret = 1'b1;
    end
  end

  // Only a fresh commit in IDLE can raise an event; a draining pipeline is ignored.
  assign detect   = m_valid & (state_q == IDLE) & (int_pend | (|m_exc));
  assign m_cancel = detect;

  // Exception vector selection.
  assign vec_base = status_i[22] ? BEV1_BASE : BEV0_BASE;
`ifdef EXC_IV_EN
  assign vec_off  = (ev_int & cause_i[23]) ? 32'h0000_0200 : 32'h0000_0180;
`else
  assign vec_off  = 32'h0000_0180;
`endif
  assign entry_pc = vec_base + vec_off;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: one TAKE cycle then one BLANK cycle after every event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (detect) state_d = TAKE;
      TAKE:    state_d = BLANK;
      BLANK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered flush/redirect and CP0 update pulses, valid in the TAKE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      exc_we      <= 1'b0;
      exc_code    <= '0;
      exc_epc     <= '0;
      exc_bd      <= 1'b0;
      badv_we     <= 1'b0;
      badv_data   <= '0;
      eret_clr    <= 1'b0;
    end else begin
      flush    <= detect;
      exc_we   <= detect & ~ev_eret;
      badv_we  <= detect & ev_badv;
      eret_clr <= detect & ev_eret;
      if (detect) begin
        redirect_pc <= ev_eret ? epc_i : entry_pc;
        exc_code    <= ev_code;
        exc_epc     <= m_inslot ? (m_pc - 32'd4) : m_pc;
        exc_bd      <= m_inslot;
        badv_data   <= ev_badv_data;
      end
    end
  end

  // Status/Cause carry many fields this block does not look at.
  logic unused_bits;
  assign unused_bits = ^{status_i, cause_i};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed, table-driven bench for exc_ctrl plus hand-written
// multi-cycle sequences (synchroniser latency, ERET blanking, reset in TAKE,
// timer interrupt vector with and without EXC_IV_EN).
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  ext_int;
  logic        timer_int;
  logic [31:0] status_i, cause_i, epc_i;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_inslot;
  logic [7:0]  m_exc;
  logic [31:0] m_addr;
  logic        m_cancel, flush, exc_we, exc_bd, badv_we, eret_clr;
  logic [31:0] redirect_pc, exc_epc, badv_data;
  logic [5:0]  hw_ip;
  logic [4:0]  exc_code;

  int n_checks = 0;
  int n_fail   = 0;

  exc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ext_int    (ext_int),
    .timer_int  (timer_int),
    .status_i   (status_i),
    .cause_i    (cause_i),
    .epc_i      (epc_i),
    .m_valid    (m_valid),
    .m_pc       (m_pc),
    .m_inslot   (m_inslot),
    .m_exc      (m_exc),
    .m_addr     (m_addr),
    .m_cancel   (m_cancel),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .hw_ip      (hw_ip),
    .exc_we     (exc_we),
    .exc_code   (exc_code),
    .exc_epc    (exc_epc),
    .exc_bd     (exc_bd),
    .badv_we    (badv_we),
    .badv_data  (badv_data),
    .eret_clr   (eret_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] status, cause, epc, pc, addr;
    logic        inslot;
    logic [7:0]  exc;
    logic        take, we, eret, bwe, bd;
    logic [4:0]  code;
    logic [31:0] rpc, xepc, badv;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [31:0] status, logic [31:0] cause, logic [31:0] epc,
                              logic [31:0] pc, logic [31:0] addr, logic inslot, logic [7:0] exc,
                              logic take, logic we, logic eret, logic bwe, logic [4:0] code,
                              logic [31:0] rpc, logic [31:0] xepc, logic bd, logic [31:0] badv);
    vec_t v;
    v.status = status; v.cause = cause; v.epc = epc; v.pc = pc; v.addr = addr;
    v.inslot = inslot; v.exc = exc; v.take = take; v.we = we; v.eret = eret;
    v.bwe = bwe; v.code = code; v.rpc = rpc; v.xepc = xepc; v.bd = bd; v.badv = badv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_valid = 1'b0; m_exc = 8'h00; m_inslot = 1'b0; m_pc = '0; m_addr = '0;
  endtask

  initial begin
    // Vector table: status, cause, epc, pc, addr, inslot, exc,
    //               take, we, eret, badv_we, code, redirect, epc_out, bd, badv
    vecs[0]  = mk(32'h0, 32'h0, 32'h0, 32'h8000_2004, 32'h0, 1, 8'h24,
                  1, 1, 0, 0, 5'd12, 32'h8000_0180, 32'h8000_2000, 1, 32'h0);
    vecs[1]  = mk(32'h0040_0000, 32'h0, 32'h0, 32'h0000_0003, 32'h0, 0, 8'h01,
                  1, 1, 0, 1, 5'd4, 32'hBFC0_0380, 32'h0000_0003, 0, 32'h0000_0003);
    vecs[2]  = mk(32'h0, 32'h0, 32'h0, 32'h0000_0000, 32'h0, 1, 8'h18,
                  1, 1, 0, 0, 5'd8, 32'h8000_0180, 32'hFFFF_FFFC, 1, 32'h0);
    vecs[3]  = mk(32'h0, 32'h0, 32'h0, 32'h8000_0040, 32'h0, 0, 8'h10,
                  1, 1, 0, 0, 5'd9, 32'h8000_0180, 32'h8000_0040, 0, 32'h0);
    vecs[4]  = mk(32'h0, 32'h0, 32'h0, 32'h8000_0050, 32'h1234_5677, 0, 8'h20,
                  1, 1, 0, 1, 5'd4, 32'h8000_0180, 32'h8000_0050, 0, 32'h1234_5677);
    vecs[5]  = mk(32'h0, 32'h0, 32'h0, 32'h8000_0060, 32'hABCD_0001, 0, 8'h40,
                  1, 1, 0, 1, 5'd5, 32'h8000_0180, 32'h8000_0060, 0, 32'hABCD_0001);
    vecs[6]  = mk(32'h0, 32'h0, 32'h0, 32'h8000_0070, 32'h0000_0002, 0, 8'h42,
                  1, 1, 0, 0, 5'd10, 32'h8000_0180, 32'h8000_0070, 0, 32'h0);
    vecs[7]  = mk(32'h0, 32'h0, 32'h8000_3000, 32'h8000_0080, 32'h0, 0, 8'h80,
                  1, 0, 1, 0, 5'd0, 32'h8000_3000, 32'h0, 0, 32'h0);
    vecs[8]  = mk(32'h0, 32'h0, 32'h8000_3000, 32'h8000_0090, 32'h0, 0, 8'h84,
                  1, 1, 0, 0, 5'd12, 32'h8000_0180, 32'h8000_0090, 0, 32'h0);
    vecs[9]  = mk(32'h0000_0101, 32'h0000_0100, 32'h0, 32'h8000_00A0, 32'h0, 0, 8'h00,
                  1, 1, 0, 0, 5'd0, 32'h8000_0180, 32'h8000_00A0, 0, 32'h0);
    vecs[10] = mk(32'h0000_0101, 32'h0000_0100, 32'h8000_3000, 32'h8000_00B0, 32'h0, 1, 8'h80,
                  1, 1, 0, 0, 5'd0, 32'h8000_0180, 32'h8000_00AC, 1, 32'h0);
    vecs[11] = mk(32'h0000_0103, 32'h0000_0100, 32'h0, 32'h8000_00C0, 32'h0, 0, 8'h02,
                  1, 1, 0, 0, 5'd10, 32'h8000_0180, 32'h8000_00C0, 0, 32'h0);
    vecs[12] = mk(32'h0000_0101, 32'h0, 32'h0, 32'h8000_00D0, 32'h0, 0, 8'h00,
                  0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    vecs[13] = mk(32'h0000_0001, 32'h0000_0300, 32'h0, 32'h8000_00E0, 32'h0, 0, 8'h00,
                  0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    vecs[14] = mk(32'h0, 32'h0080_0000, 32'h0, 32'h8000_00F0, 32'h0, 0, 8'h02,
                  1, 1, 0, 0, 5'd10, 32'h8000_0180, 32'h8000_00F0, 0, 32'h0);

    // Reset state
    rst = 1'b0; ext_int = '0; timer_int = 1'b0;
    status_i = '0; cause_i = '0; epc_i = '0;
    idle_inputs();
    step(); step();
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_hw_ip", hw_ip, 0);
    check("rst_exc_we", exc_we, 0);
    check("rst_exc_code", exc_code, 0);
    check("rst_exc_epc", exc_epc, 0);
    check("rst_badv_we", badv_we, 0);
    check("rst_badv_data", badv_data, 0);
    check("rst_eret_clr", eret_clr, 0);
    check("rst_exc_bd", exc_bd, 0);
    rst = 1'b1;
    step();

    // Table-driven single-commit vectors
    for (int i = 0; i < NV; i++) begin
      status_i = vecs[i].status; cause_i = vecs[i].cause; epc_i = vecs[i].epc;
      m_pc = vecs[i].pc; m_addr = vecs[i].addr; m_inslot = vecs[i].inslot;
      m_exc = vecs[i].exc; m_valid = 1'b1;
      #1;
      check($sformatf("v%0d_m_cancel", i), m_cancel, vecs[i].take);
      step();
      m_valid = 1'b0;
      check($sformatf("v%0d_flush", i), flush, vecs[i].take);
      check($sformatf("v%0d_exc_we", i), exc_we, vecs[i].we);
      check($sformatf("v%0d_eret_clr", i), eret_clr, vecs[i].eret);
      check($sformatf("v%0d_badv_we", i), badv_we, vecs[i].bwe);
      if (vecs[i].take) check($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].rpc);
      if (vecs[i].we) begin
        check($sformatf("v%0d_code", i), exc_code, vecs[i].code);
        check($sformatf("v%0d_epc", i), exc_epc, vecs[i].xepc);
        check($sformatf("v%0d_bd", i), exc_bd, vecs[i].bd);
      end
      if (vecs[i].bwe) check($sformatf("v%0d_badv", i), badv_data, vecs[i].badv);
      step();
      check($sformatf("v%0d_flush_gone", i), flush, 0);
      step();
      idle_inputs();
    end

    // External interrupt through the synchroniser
    status_i = 32'h0040_0401; cause_i = '0; epc_i = '0;
    ext_int = 6'b000001;
    step(); check("sync_hw_ip_c1", hw_ip, 6'h00);
    step(); check("sync_hw_ip_c2", hw_ip, 6'h00);
    step(); check("sync_hw_ip_c3", hw_ip, 6'h01);
    step(); check("int_no_commit_flush", flush, 0);
    m_valid = 1'b1; m_pc = 32'h8000_1000; m_exc = 8'h00; m_inslot = 1'b0;
    #1; check("int_m_cancel", m_cancel, 1);
    step();
    idle_inputs();
    check("int_flush", flush, 1);
    check("int_exc_we", exc_we, 1);
    check("int_code", exc_code, 0);
    check("int_epc", exc_epc, 32'h8000_1000);
    check("int_redirect", redirect_pc, 32'hBFC0_0380);
    ext_int = '0;
    for (int i = 0; i < 5; i++) step();
    check("int_hw_ip_clear", hw_ip, 6'h00);
    status_i = '0;

    // ERET followed by ri commits while draining
    epc_i = 32'h8000_3000;
    m_valid = 1'b1; m_exc = 8'h80; m_pc = 32'h8000_0200;
    #1; check("eret_m_cancel", m_cancel, 1);
    step();
    m_exc = 8'h02; m_pc = 32'h8000_0300;
    check("eret_clr_pulse", eret_clr, 1);
    check("eret_redirect", redirect_pc, 32'h8000_3000);
    check("eret_exc_we", exc_we, 0);
    check("eret_badv_we", badv_we, 0);
    #1; check("eret_take_ignore", m_cancel, 0);
    step();
    check("eret_n2_flush", flush, 0);
    check("eret_n2_clr", eret_clr, 0);
    #1; check("eret_blank_ignore", m_cancel, 0);
    step();
    check("eret_n3_flush", flush, 0);
    #1; check("eret_n3_accept", m_cancel, 1);
    step();
    idle_inputs();
    check("eret_ri_flush", flush, 1);
    check("eret_ri_code", exc_code, 10);
    step(); step();

    // Reset asserted during TAKE
    m_valid = 1'b1; m_exc = 8'h02; m_pc = 32'h8000_0400;
    step();
    idle_inputs();
    check("rtake_flush_pre", flush, 1);
    rst = 1'b0;
    #1;
    check("rtake_flush", flush, 0);
    check("rtake_exc_we", exc_we, 0);
    check("rtake_redirect", redirect_pc, 0);
    step();
    rst = 1'b1;
    #1;
    m_valid = 1'b1; m_exc = 8'h02; m_pc = 32'h8000_0500;
    #1; check("rtake_idle_accept", m_cancel, 1);
    step();
    idle_inputs();
    check("rtake_after_flush", flush, 1);
    step(); step();

    // Timer interrupt with Cause.IV set, BEV=0
    status_i = 32'h0000_8001; cause_i = 32'h0080_0000;
    timer_int = 1'b1;
    #1; check("timer_hw_ip_pre", hw_ip, 6'h00);
    step(); check("timer_hw_ip", hw_ip, 6'h20);
    m_valid = 1'b1; m_pc = 32'h8000_0600; m_exc = 8'h00;
    step();
    idle_inputs();
    timer_int = 1'b0;
    check("timer_code", exc_code, 0);
    check("timer_exc_we", exc_we, 1);
`ifdef EXC_IV_EN
    check("timer_redirect", redirect_pc, 32'h8000_0200);
`else
    check("timer_redirect", redirect_pc, 32'h8000_0180);
`endif
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller at the memory-stage commit point. Synchronises the external interrupt lines and merges them with the CP0 timer interrupt. Arbitrates interrupt and instruction exceptions by MIPS priority and handles ERET. Issues a one-cycle pipeline flush with redirect PC, and the matching exception-entry update pulse that the CP0 register file consumes.

## Interface
- `SYNC_STAGES`, 2: flop stages on each `ext_int` line (minimum 2).
- `BEV1_BASE`, 32'hBFC0_0200: vector base when Status.BEV=1.
- `BEV0_BASE`, 32'h8000_0000: vector base when Status.BEV=0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low.
- `ext_int` in 6: asynchronous hardware interrupt lines.
- `timer_int` in 1: CP0 timer interrupt, synchronous to `clk`.
- `status_i` in 32: live CP0 Status.
- `cause_i` in 32: live CP0 Cause.
- `epc_i` in 32: live CP0 EPC.
- `m_valid` in 1: memory-stage instruction is presented for commit.
- `m_pc` in 32: PC of that instruction.
- `m_inslot` in 1: instruction is in a branch delay slot.
- `m_exc` in 8: exception flags `{eret, ades, adel, bp, sys, ov, ri, adel_if}`.
- `m_addr` in 32: load/store effective address.
- `m_cancel` out 1: combinational; suppresses the current instruction's writeback.
- `flush` out 1: registered, one-cycle pipeline flush.
- `redirect_pc` out 32: fetch target, valid while `flush`=1.
- `hw_ip` out 6: synchronised interrupt pending bits, to Cause.IP[7:2].
- `exc_we` out 1: exception-entry write pulse to CP0 (sets EXL, EPC, Cause.BD, Cause.ExcCode).
- `exc_code` out 5: ExcCode for the entry write.
- `exc_epc` out 32: EPC for the entry write.
- `exc_bd` out 1: Cause.BD for the entry write.
- `badv_we` out 1: BadVAddr write enable.
- `badv_data` out 32: BadVAddr write data.
- `eret_clr` out 1: pulse that clears Status.EXL.

## Operation
- Synchroniser: `ext_int` passes through `SYNC_STAGES` flops. `hw_ip = {sync[5] | timer_int, sync[4:0]}`, registered.
- Interrupt pending condition: `int_pend = IE & ~EXL & |({hw_ip, cause_i[9:8]} & IM)`.
- Event selection at commit (`m_valid`=1, state IDLE), highest priority first:
  - Int, code 0.
  - adel_if, code 4, BadVAddr = `m_pc`.
  - ri, code 10.
  - ov, code 12.
  - sys, code 8.
  - bp, code 9.
  - adel, code 4, BadVAddr = `m_addr`.
  - ades, code 5, BadVAddr = `m_addr`.
  - eret.
- `m_cancel = m_valid & IDLE & (int_pend | |m_exc)`. It is combinational in the detect cycle.
- Exception entry:
  - `exc_epc = m_inslot ? m_pc-4 : m_pc`; `exc_bd = m_inslot`.
  - `redirect_pc = (BEV ? BEV1_BASE : BEV0_BASE) + 32'h180`.
- ERET:
  - `redirect_pc = epc_i`; `eret_clr` = 1.
  - `exc_we` = 0 and `badv_we` = 0.
- FSM states: IDLE, TAKE, BLANK.
  - IDLE → TAKE on a detected event.
  - TAKE → BLANK unconditionally.
  - BLANK → IDLE unconditionally.
  - `m_valid` is ignored in TAKE and BLANK; no second event is taken from a draining pipeline.
- Arithmetic: all address arithmetic is 32-bit modulo 2^32, so `m_pc`=0 gives EPC 32'hFFFF_FFFC.

## Timing
- Detect in cycle N. In cycle N+1 (state TAKE), exactly one of these outputs pulses high for one cycle, alongside `flush` and `redirect_pc`:
  - `exc_we` (with `badv_we` when applicable), or
  - `eret_clr`.
- Earliest next accepted event is cycle N+3.
- `ext_int` to `hw_ip` latency: `SYNC_STAGES`+1 cycles. `timer_int` to `hw_ip` latency: 1 cycle.
- Reset values:
  - All registered outputs are 0: `flush`, `redirect_pc`, `hw_ip`, `exc_we`, `exc_code`, `exc_epc`, `exc_bd`, `badv_we`, `badv_data`, `eret_clr`.
  - Synchroniser flops are 0; state is IDLE.
- Reset asserted mid-TAKE or mid-BLANK: outputs drop to 0 immediately; state is IDLE after release.
- Interrupt pending together with an ERET commit: Int wins. This case only arises if software cleared EXL before ERET.
- `int_pend` asserting in a cycle with `m_valid`=0: no action; the interrupt is taken at the next commit.

## Configuration
- Macro: `EXC_IV_EN`.
- Defined: when the event is Int and Cause.IV (`cause_i[23]`)=1, the vector offset is 32'h200 instead of 32'h180.
- Undefined: Cause.IV is ignored and every exception uses offset 32'h180.

## Test plan
- Status=32'h0040_0401 (BEV=1, IM2, IE), `ext_int[0]` asserted:
  - `hw_ip[0]`=1 after 3 cycles.
  - At the next commit with `m_pc`=32'h8000_1000: `flush`, `exc_we`, `exc_code`=0, `exc_epc`=32'h8000_1000, `redirect_pc`=32'hBFC0_0380.
- `m_exc` = adel|ov with `m_inslot`=1, `m_pc`=32'h8000_2004, BEV=0:
  - `exc_code`=12, `exc_bd`=1, `exc_epc`=32'h8000_2000, `badv_we`=0, `redirect_pc`=32'h8000_0180.
- `adel_if` with `m_pc`=32'h0000_0003:
  - `exc_code`=4, `badv_we`=1, `badv_data`=32'h0000_0003.
- ERET with `epc_i`=32'h8000_3000, then a ri commit in each of the next 2 cycles:
  - `eret_clr`=1 and `redirect_pc`=32'h8000_3000 in cycle N+1.
  - Both ri commits are ignored.
  - A ri commit at N+3 is taken.
- `rst` pulled low during TAKE:
  - `flush`/`exc_we` go to 0 without a clock edge.
  - The FSM is in IDLE after release.
- With `EXC_IV_EN`, Cause.IV=1, BEV=0, timer interrupt:
  - `redirect_pc`=32'h8000_0200.
  - Without the macro, `redirect_pc`=32'h8000_0180.
